// File: rtl/shared_resource_arbiter.sv
// shared_resource_arbiter
// -----------------------------------------------------------------------------
// Front end that lets NUM_CLIENTS initiators share one shared_resource lookup
// port. One request is in flight at a time: the granted key is registered onto
// resource_input, the arbiter waits LATENCY cycles for resource_output, then
// returns the result to the granted client with a one-cycle strobe. A result
// of 32'hFFFFFFFF ("no entry") is flagged on rsp_err.
//
// Configuration macro:
//   SHARED_RESOURCE_ARB_FIXED_PRIO_EN  defined   -> fixed priority (lowest index wins)
//                                      undefined -> round-robin (default)
//
// Ports:
//   clk             in   clock, all logic on posedge
//   reset           in   synchronous active-high reset
//   req_valid       in   [NUM_CLIENTS]     per-client request valid
//   req_addr        in   [NUM_CLIENTS*32]  per-client key, client i at [32*i+31:32*i]
//   req_ready       out  [NUM_CLIENTS]     one-hot accept (combinational)
//   rsp_valid       out  [NUM_CLIENTS]     one-hot registered response strobe
//   rsp_data        out  [32]              registered response data
//   rsp_err         out                    registered "no entry" flag
//   resource_input  out  [32]              registered key to shared_resource
//   resource_output in   [32]              data from shared_resource
//   dbg_state_o     out  [2]               FSM state (0 IDLE, 1 WAIT, 2 RESP)
//
// Handshake: a request transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high; a client holds req_valid/req_addr until then and
// may drop req_valid beforehand without leaving any state behind.
// -----------------------------------------------------------------------------
module shared_resource_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int LATENCY     = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CLIENTS-1:0]    req_valid,
  input  logic [NUM_CLIENTS*32-1:0] req_addr,
  output logic [NUM_CLIENTS-1:0]    req_ready,
  output logic [NUM_CLIENTS-1:0]    rsp_valid,
  output logic [31:0]               rsp_data,
  output logic                      rsp_err,
  output logic [31:0]               resource_input,
  input  logic [31:0]               resource_output,
  output logic [1:0]                dbg_state_o
);

  localparam int GW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [GW-1:0]          gnt_q, gnt_d;
  logic [31:0]            res_in_q, res_in_d;
  logic [NUM_CLIENTS-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]            rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;

  logic [GW-1:0]          pick;
  logic                   pick_vld;
  logic                   accept;

`ifdef SHARED_RESOURCE_ARB_FIXED_PRIO_EN
  // Lowest-index valid client wins; scanning downwards lets the lowest
  // index overwrite any higher one.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        pick     = GW'(i);
        pick_vld = 1'b1;
      end
    end
  end
`else
  logic [GW-1:0] last_q;

  // Round-robin: search starts at last_q+1. Scanning from the farthest
  // offset to the nearest makes the nearest valid client the final winner.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NUM_CLIENTS; k >= 1; k--) begin
      if (req_valid[(int'(last_q) + k) % NUM_CLIENTS]) begin
        pick     = GW'((int'(last_q) + k) % NUM_CLIENTS);
        pick_vld = 1'b1;
      end
    end
  end

  // Reset value makes client 0 the first one searched.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= GW'(NUM_CLIENTS - 1);
    end else if (accept) begin
      last_q <= pick;
    end
  end
`endif

  assign accept = (state_q == ST_IDLE) && pick_vld && !reset;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gnt_q       <= '0;
      res_in_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      res_in_q    <= res_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    res_in_d    = res_in_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          res_in_d = req_addr[32*int'(pick) +: 32];
          gnt_d    = pick;
          cnt_d    = 3'(LATENCY);
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Counter hits zero in the cycle resource_output becomes valid.
        if (cnt_q == 3'd0) begin
          rsp_data_d         = resource_output;
          rsp_err_d          = (resource_output == 32'hFFFF_FFFF);
          rsp_valid_d        = '0;
          rsp_valid_d[gnt_q] = 1'b1;
          state_d            = ST_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        rsp_valid_d = '0;
        res_in_d    = '0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[pick] = 1'b1;
    end
    dbg_state_o = state_q;
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;
  assign resource_input = res_in_q;

endmodule

// File: tb/tb_shared_resource_arbiter.sv
module tb_shared_resource_arbiter;

  localparam int NC  = 4;
  localparam int LAT = 1;
  localparam int EW  = NC + 1 + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [NC-1:0]        req_valid;
  logic [NC*32-1:0]     req_addr;
  logic [NC-1:0]        req_ready;
  logic [NC-1:0]        rsp_valid;
  logic [31:0]          rsp_data;
  logic                 rsp_err;
  logic [31:0]          resource_input;
  logic [31:0]          resource_output;
  logic [1:0]           dbg_state;

  shared_resource_arbiter #(.NUM_CLIENTS(NC), .LATENCY(LAT)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .rsp_err         (rsp_err),
    .resource_input  (resource_input),
    .resource_output (resource_output),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- shared_resource model ----------------
  function automatic logic [31:0] lookup(input logic [31:0] a);
    case (a)
      32'd1:   lookup = 32'd92;
      32'd31:  lookup = 32'd97;
      32'd13:  lookup = 32'd6;
      32'd2:   lookup = 32'd48;
      32'd7:   lookup = 32'd86;
      32'd5:   lookup = 32'd555;
      default: lookup = 32'hFFFF_FFFF;
    endcase
  endfunction

  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= lookup(resource_input);
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign resource_output = pipe[LAT-1];

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            grant_q[$];
  int            grant_cyc_q[$];
  logic [NC-1:0] acc;
  int            cyc    = 0;
  int            checks = 0;
  int            errors = 0;

  // One cycle: sample at negedge, then return just after the next posedge.
  task automatic tick();
    logic [EW-1:0] e;
    logic [NC-1:0] oh;
    logic [31:0]   d;
    int            ec;
    @(negedge clk);
    cyc++;
    checks++;
    if (((req_ready & (req_ready - 1'b1)) != '0) || ((req_ready & ~req_valid) != '0)) begin
      errors++;
      $display("FAIL ready_onehot cyc %0d req_ready=%b req_valid=%b", cyc, req_ready, req_valid);
    end
    acc = req_valid & req_ready;
    for (int i = 0; i < NC; i++) begin
      if (acc[i]) begin
        oh    = '0;
        oh[i] = 1'b1;
        d     = lookup(req_addr[32*i +: 32]);
        exp_q.push_back({oh, (d == 32'hFFFF_FFFF), d});
        exp_cyc_q.push_back(cyc + LAT + 2);
        grant_q.push_back(i);
        grant_cyc_q.push_back(cyc);
      end
    end
    if (rsp_valid != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_rsp cyc %0d rsp_valid=%b data=%h", cyc, rsp_valid, rsp_data);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if ({rsp_valid, rsp_err, rsp_data} !== e || cyc != ec) begin
          errors++;
          $display("FAIL rsp cyc %0d got v=%b err=%b data=%h, want v=%b err=%b data=%h at cyc %0d",
                   cyc, rsp_valid, rsp_err, rsp_data, e[EW-1 -: NC], e[32], e[31:0], ec);
        end
      end
    end else if (exp_cyc_q.size() > 0 && cyc >= exp_cyc_q[0]) begin
      checks++;
      errors++;
      e  = exp_q.pop_front();
      ec = exp_cyc_q.pop_front();
      $display("FAIL missing_rsp cyc %0d rsp_valid=%b want v=%b data=%h", cyc, rsp_valid, e[EW-1 -: NC], e[31:0]);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [31:0] a);
    req_addr[32*i +: 32] = a;
    req_valid[i]         = 1'b1;
  endtask

  task automatic wait_accept(input int i, input int max_cyc);
    bit got = 1'b0;
    for (int n = 0; n < max_cyc && !got; n++) begin
      tick();
      if (acc[i]) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout client %0d got none want accept within %0d", i, max_cyc);
    end
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending %0d want 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    req_valid = '0;
    exp_q.delete();
    exp_cyc_q.delete();
    tick();
    tick();
    reset = 1'b0;
    grant_q.delete();
    grant_cyc_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset     = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NC; i++) req_addr[32*i +: 32] = 32'd1;
    tick();
    tick();
    checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || rsp_data !== 32'd0 || rsp_err !== 1'b0 ||
        resource_input !== 32'd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_values ready=%b v=%b data=%h err=%b rin=%h st=%0d want all 0",
               req_ready, rsp_valid, rsp_data, rsp_err, resource_input, dbg_state);
    end
    req_valid = '0;
    reset     = 1'b0;
    grant_q.delete();
    grant_cyc_q.delete();
  endtask

  task automatic test_single();
    apply_reset();
    set_req(0, 32'd1);
    tick();
    checks++;
    if (acc !== 4'b0001) begin
      errors++;
      $display("FAIL single_accept got acc=%b want 0001", acc);
    end
    req_valid[0] = 1'b0;
    checks++;
    if (resource_input !== 32'd1) begin
      errors++;
      $display("FAIL single_rin got %h want 00000001", resource_input);
    end
    drain();
    checks++;
    if (resource_input !== 32'd0 || rsp_data !== 32'd92 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL single_after rin=%h data=%0d err=%b want rin 0 data 92 err 0",
               resource_input, rsp_data, rsp_err);
    end
  endtask

  task automatic test_arbitration();
    int want[6];
`ifdef SHARED_RESOURCE_ARB_FIXED_PRIO_EN
    want = '{0, 0, 0, 0, 0, 1};
`else
    want = '{0, 1, 2, 3, 0, 1};
`endif
    apply_reset();
    set_req(0, 32'd31);
    set_req(1, 32'd13);
    set_req(2, 32'd2);
    set_req(3, 32'd7);
    for (int n = 0; n < 80 && grant_q.size() < 6; n++) begin
      tick();
      if (grant_q.size() == 5) req_valid[0] = 1'b0;
    end
    req_valid = '0;
    checks++;
    if (grant_q.size() != 6) begin
      errors++;
      $display("FAIL arb_count got %0d grants want 6", grant_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (grant_q[k] != want[k]) begin
          errors++;
          $display("FAIL arb_order idx %0d got client %0d want %0d", k, grant_q[k], want[k]);
        end
        if (k > 0) begin
          checks++;
          if (grant_cyc_q[k] - grant_cyc_q[k-1] != LAT + 3) begin
            errors++;
            $display("FAIL arb_spacing idx %0d got %0d want %0d", k,
                     grant_cyc_q[k] - grant_cyc_q[k-1], LAT + 3);
          end
        end
      end
    end
    drain();
  endtask

  task automatic test_no_entry();
    set_req(2, 32'd0);
    wait_accept(2, 10);
    drain();
    set_req(2, 32'd40);
    wait_accept(2, 10);
    drain();
    checks++;
    if (rsp_data !== 32'hFFFF_FFFF || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL no_entry_hold data=%h err=%b want ffffffff 1", rsp_data, rsp_err);
    end
  endtask

  task automatic reset_mid(input int c, input logic [31:0] a);
    apply_reset();
    set_req(c, a);
    wait_accept(c, 10);
    reset = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || rsp_data !== 32'd0 || rsp_err !== 1'b0 ||
        resource_input !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs ready=%b v=%b data=%h err=%b rin=%h want all 0",
               req_ready, rsp_valid, rsp_data, rsp_err, resource_input);
    end
    grant_q.delete();
    set_req(0, 32'd1);
    set_req(1, 32'd13);
    for (int n = 0; n < 10 && grant_q.size() == 0; n++) tick();
    req_valid = '0;
    checks++;
    if (grant_q.size() == 0 || grant_q[0] != 0) begin
      errors++;
      $display("FAIL mid_reset_grant got %0d want client 0",
               (grant_q.size() == 0) ? -1 : grant_q[0]);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    reset_mid(1, 32'd5);
    reset_mid(0, 32'd2);
  endtask

  task automatic test_drop();
    int n3 = 0;
    grant_q.delete();
    set_req(0, 32'd7);
    wait_accept(0, 10);
    set_req(3, 32'd31);
    tick();
    req_valid[3] = 1'b0;
    drain();
    tick();
    foreach (grant_q[k]) if (grant_q[k] == 3) n3++;
    checks++;
    if (n3 != 0 || grant_q.size() != 1) begin
      errors++;
      $display("FAIL drop_grant got %0d grants (%0d to client 3) want 1 (0)", grant_q.size(), n3);
    end
  endtask

  task automatic test_random();
    logic [31:0] addrs[8];
    int c;
    addrs = '{32'd1, 32'd31, 32'd13, 32'd2, 32'd7, 32'd5, 32'd0, 32'd40};
    for (int n = 0; n < 10; n++) begin
      c = $urandom_range(0, NC - 1);
      set_req(c, addrs[$urandom_range(0, 7)]);
      wait_accept(c, 10);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
    drain();
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    test_reset();
    test_single();
    test_arbitration();
    test_no_entry();
    test_reset_mid();
    test_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
